// File: rtl/cnn_ctrl_pkg.sv
// Shared types and width helpers for the CNN layer sequencer.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    MAC,
    WRITE,
    NEXT,
    DONE
  } state_t;

  // An index into a set of n items. It is still one bit wide when n is 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_layer_seq_ctrl_if.sv
// Control/handshake bundle between the layer sequencer and its buffers and datapath.
interface cnn_layer_seq_ctrl_if
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_KERNELS = 4,
  parameter int KERNEL_ROWS = 4,
  parameter int OUT_W       = 4,
  parameter int OUT_H       = 4
);

  localparam int KW = idx_w(NUM_KERNELS);
  localparam int RW = idx_w(KERNEL_ROWS);
  localparam int CW = idx_w(OUT_W);
  localparam int HW = idx_w(OUT_H);

  logic                   start;
  logic                   reuse_kernels;
  logic                   abort;
  logic                   in_valid;
  logic                   out_ready;
  logic [NUM_KERNELS-1:0] kernel_we;
  logic [RW-1:0]          kernel_row;
  logic                   load_sel;
  logic                   win_en;
  logic [KW-1:0]          kernel_sel;
  logic                   acc_clr;
  logic                   mac_en;
  logic                   out_wr;
  logic [CW-1:0]          out_col;
  logic [HW-1:0]          out_row;
  logic                   weights_valid;
  logic                   busy;
  logic                   done;

  modport master (
    output start, reuse_kernels, abort, in_valid, out_ready,
    input  kernel_we, kernel_row, load_sel, win_en, kernel_sel, acc_clr, mac_en,
           out_wr, out_col, out_row, weights_valid, busy, done
  );

  modport slave (
    input  start, reuse_kernels, abort, in_valid, out_ready,
    output kernel_we, kernel_row, load_sel, win_en, kernel_sel, acc_clr, mac_en,
           out_wr, out_col, out_row, weights_valid, busy, done
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MODULUS up-counter. It has a synchronous clear and a combinational wrap pulse.
module mod_counter
  import cnn_ctrl_pkg::*;
#(
  parameter int MODULUS = 4,
  parameter int W       = idx_w(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  // NOTE: state is updated with non-blocking assignments only. Every reader then sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst)         count <= '0;
    else if (clr)     count <= '0;
    else if (en)      count <= (count == LAST) ? '0 : count + W'(1);
  end

endmodule

// File: rtl/cnn_layer_seq_ctrl.sv
// Conv-layer sequencer. It loads kernels, then walks the output positions.
// At each position it fetches the input window and runs MAC and WRITE once per kernel.
module cnn_layer_seq_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_KERNELS  = 4,
  parameter int KERNEL_ROWS  = 4,
  parameter int FETCH_CYCLES = 9,
  parameter int MAC_CYCLES   = 9,
  parameter int OUT_W        = 4,
  parameter int OUT_H        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cnn_layer_seq_ctrl_if.slave  bus
);

  localparam int KW = idx_w(NUM_KERNELS);
  localparam int RW = idx_w(KERNEL_ROWS);
  localparam int FW = idx_w(FETCH_CYCLES);
  localparam int MW = idx_w(MAC_CYCLES);
  localparam int CW = idx_w(OUT_W);
  localparam int HW = idx_w(OUT_H);
  localparam logic [NUM_KERNELS-1:0] WE_ONE = NUM_KERNELS'(1);

  state_t state_q, state_d;
  logic   weights_valid_q, weights_valid_d;
  logic   abort_hit, clr_all;

  logic          r_en, k_en, col_en, row_en;
  logic          r_wrap, k_wrap, f_wrap, m_wrap, col_wrap, row_wrap;
  logic [RW-1:0] r_cnt;
  logic [KW-1:0] k_cnt;
  logic [FW-1:0] f_cnt;
  logic [MW-1:0] m_cnt;
  logic [CW-1:0] col_cnt;
  logic [HW-1:0] row_cnt;
  logic          unused_f_cnt;

  assign abort_hit = bus.abort && (state_q != IDLE);
  // Abort, IDLE and DONE all clear the loop counters. A new frame therefore always starts at zero.
  assign clr_all   = abort_hit || (state_q == IDLE) || (state_q == DONE);

  assign r_en   = (state_q == LOAD) && bus.in_valid;
  assign k_en   = (r_en && r_wrap) || ((state_q == WRITE) && bus.out_ready);
  assign col_en = (state_q == NEXT);
  assign row_en = col_wrap;

  mod_counter #(.MODULUS(KERNEL_ROWS)) u_r_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(r_en), .count(r_cnt), .wrap(r_wrap)
  );
  mod_counter #(.MODULUS(NUM_KERNELS)) u_k_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(k_en), .count(k_cnt), .wrap(k_wrap)
  );
  mod_counter #(.MODULUS(FETCH_CYCLES)) u_f_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(state_q == FETCH), .count(f_cnt), .wrap(f_wrap)
  );
  mod_counter #(.MODULUS(MAC_CYCLES)) u_m_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(state_q == MAC), .count(m_cnt), .wrap(m_wrap)
  );
  mod_counter #(.MODULUS(OUT_W)) u_col_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(col_en), .count(col_cnt), .wrap(col_wrap)
  );
  mod_counter #(.MODULUS(OUT_H)) u_row_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(row_en), .count(row_cnt), .wrap(row_wrap)
  );

  // The fetch phase only needs the wrap pulse of its counter.
  assign unused_f_cnt = ^f_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      weights_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      weights_valid_q <= weights_valid_d;
    end
  end

  // NOTE: every combinational output gets a default before the case. No path can then leave it unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    weights_valid_d = weights_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.reuse_kernels && weights_valid_q) begin
            state_d = FETCH;
          end else begin
            state_d         = LOAD;
            weights_valid_d = 1'b0;
          end
        end
      end
      LOAD: begin
        if (k_wrap) begin
          state_d         = FETCH;
          weights_valid_d = 1'b1;
        end
      end
      FETCH:   if (f_wrap) state_d = MAC;
      MAC:     if (m_wrap) state_d = WRITE;
      WRITE:   if (bus.out_ready) state_d = k_wrap ? NEXT : MAC;
      NEXT:    state_d = row_wrap ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An abort during the kernel load leaves partial weights, so they must not be reused.
    if (abort_hit) begin
      state_d = IDLE;
      if (state_q == LOAD) weights_valid_d = 1'b0;
    end
  end

  always_comb begin
    bus.kernel_we  = '0;
    bus.kernel_row = '0;
    bus.load_sel   = 1'b0;
    bus.win_en     = 1'b0;
    bus.kernel_sel = '0;
    bus.acc_clr    = 1'b0;
    bus.mac_en     = 1'b0;
    bus.out_wr     = 1'b0;
    bus.done       = 1'b0;
    case (state_q)
      LOAD: begin
        bus.kernel_we  = WE_ONE << k_cnt;
        bus.kernel_row = r_cnt;
        bus.load_sel   = 1'b1;
      end
      FETCH: bus.win_en = 1'b1;
      MAC: begin
        bus.mac_en     = 1'b1;
        bus.acc_clr    = (m_cnt == '0);
        bus.kernel_sel = k_cnt;
      end
      WRITE: begin
        bus.out_wr     = 1'b1;
        bus.kernel_sel = k_cnt;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_col       = col_cnt;
  assign bus.out_row       = row_cnt;
  assign bus.weights_valid = weights_valid_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cnn_layer_seq_ctrl.sv
// Self-checking bench for cnn_layer_seq_ctrl. A frame-level reference model derives the expected beat/result order and the frame latency.
module tb_cnn_layer_seq_ctrl;
  import cnn_ctrl_pkg::*;

  localparam int NK   = 2;
  localparam int KR   = 2;
  localparam int FC   = 3;
  localparam int MC   = 3;
  localparam int OW   = 2;
  localparam int OH   = 1;
  localparam int P    = OW * OH;
  localparam int WORK = P * (FC + NK * (MC + 1) + 1);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   wv_exp;
  int   d;

  cnn_layer_seq_ctrl_if #(
    .NUM_KERNELS(NK), .KERNEL_ROWS(KR), .OUT_W(OW), .OUT_H(OH)
  ) bus ();

  cnn_layer_seq_ctrl #(
    .NUM_KERNELS(NK), .KERNEL_ROWS(KR), .FETCH_CYCLES(FC),
    .MAC_CYCLES(MC), .OUT_W(OW), .OUT_H(OH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{bus.kernel_we, bus.kernel_row, bus.load_sel, bus.win_en, bus.kernel_sel,
             bus.acc_clr, bus.mac_en, bus.out_wr, bus.out_col, bus.out_row,
             bus.weights_valid, bus.busy, bus.done};
  endfunction

  task automatic wait_mac(input string tag);
    int n = 0;
    while (!bus.mac_en && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check({tag, "_mac_timeout"}, 0, 1);
  endtask

  // iv_mode: 0 in_valid always 1, 1 two-cycle gap at kernel 0 row 1, 2 random.
  // or_mode: 0 out_ready always 1, 1 five-cycle hold at the first write, 2 random.
  task automatic run_frame(input string tag, input bit reuse, input int iv_mode,
                           input int or_mode, output int done_at);
    int  beat_k[$], beat_r[$], wr_c[$], wr_r[$], wr_k[$];
    bit  expect_load;
    int  iv_low = 0, stall = 0, iv_gap = 0, or_gap = 0, load_cyc = 0;
    int  first_win = -1, win_n = 0, mac_n = 0, clr_n = 0, wr_seen = 0, first_wr_len = 0;
    int  exp_load, beat_bad = 0, wr_bad = 0;
    bit  acc_ok = 1, busy_ok = 1, prev_mac = 0, iv, rdy;

    expect_load = !(reuse && wv_exp);
    if (expect_load)
      for (int k = 0; k < NK; k++)
        for (int r = 0; r < KR; r++) begin
          beat_k.push_back(k);
          beat_r.push_back(r);
        end
    for (int row = 0; row < OH; row++)
      for (int col = 0; col < OW; col++)
        for (int k = 0; k < NK; k++) begin
          wr_c.push_back(col);
          wr_r.push_back(row);
          wr_k.push_back(k);
        end

    bus.start = 1'b1;
    bus.reuse_kernels = reuse;
    step();
    bus.start = 1'b0;
    bus.reuse_kernels = 1'b0;
    done_at = -1;

    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (bus.done) begin
        done_at = cyc;
        break;
      end
      if (!bus.busy) busy_ok = 0;
      if (bus.win_en && first_win < 0) first_win = cyc;
      win_n += int'(bus.win_en);
      mac_n += int'(bus.mac_en);
      clr_n += int'(bus.acc_clr);
      if (bus.acc_clr && (!bus.mac_en || prev_mac)) acc_ok = 0;
      prev_mac = bus.mac_en;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      if (bus.load_sel) begin
        load_cyc++;
        iv = (iv_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (iv_mode == 1 && beat_k.size() == NK * KR - 1 && iv_gap < 2) begin
          iv = 1'b0;
          iv_gap++;
        end
        if (beat_k.size() == 0) begin
          beat_bad++;
        end else if (bus.kernel_we !== NK'(1 << beat_k[0]) || bus.kernel_row !== 1'(beat_r[0])) begin
          beat_bad++;
          $display("%s beat: kernel_we=%b row=%0d want k=%0d r=%0d", tag,
                   bus.kernel_we, bus.kernel_row, beat_k[0], beat_r[0]);
        end
        bus.in_valid = iv;
        if (!iv) iv_low++;
        else if (beat_k.size() > 0) begin
          void'(beat_k.pop_front());
          void'(beat_r.pop_front());
        end
      end

      if (bus.out_wr) begin
        rdy = (or_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (or_mode == 1 && wr_seen == 0 && or_gap < 5) begin
          rdy = 1'b0;
          or_gap++;
        end
        if (wr_seen == 0) first_wr_len++;
        if (wr_c.size() == 0) begin
          wr_bad++;
        end else if (bus.out_col !== 1'(wr_c[0]) || bus.out_row !== 1'(wr_r[0]) ||
                     bus.kernel_sel !== 1'(wr_k[0])) begin
          wr_bad++;
          $display("%s write: col=%0d row=%0d ksel=%0d want %0d/%0d/%0d", tag,
                   bus.out_col, bus.out_row, bus.kernel_sel, wr_c[0], wr_r[0], wr_k[0]);
        end
        bus.out_ready = rdy;
        if (!rdy) stall++;
        else if (wr_c.size() > 0) begin
          void'(wr_c.pop_front());
          void'(wr_r.pop_front());
          void'(wr_k.pop_front());
          wr_seen++;
        end
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    exp_load = expect_load ? NK * KR + iv_low : 0;
    check({tag, "_done_seen"}, 32'(done_at > 0), 1);
    check({tag, "_latency"}, done_at, 1 + exp_load + WORK + stall);
    check({tag, "_load_cycles"}, load_cyc, exp_load);
    check({tag, "_first_win"}, first_win, 1 + exp_load);
    check({tag, "_beat_order"}, beat_bad, 0);
    check({tag, "_beats_left"}, beat_k.size(), 0);
    check({tag, "_write_order"}, wr_bad, 0);
    check({tag, "_writes_left"}, wr_c.size(), 0);
    check({tag, "_win_en_count"}, win_n, P * FC);
    check({tag, "_mac_en_count"}, mac_n, P * NK * MC);
    check({tag, "_acc_clr_count"}, clr_n, P * NK);
    check({tag, "_acc_clr_first_only"}, acc_ok, 1);
    check({tag, "_busy_held"}, busy_ok, 1);
    if (or_mode == 1) check({tag, "_first_write_len"}, first_wr_len, 6);
    if (expect_load) wv_exp = 1'b1;
    check({tag, "_wv_at_done"}, bus.weights_valid, wv_exp);
    step();
    check({tag, "_idle_after"}, {bus.busy, bus.done}, 2'b00);
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.reuse_kernels = 1'b0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    wv_exp = 1'b0;
    step();
    step();
    check("reset_outputs", any_out(), 0);
    rst = 1'b1;
    step();

    run_frame("cold", 1'b0, 0, 0, d);
    check("cold_done_cycle", d, 29);
    run_frame("reuse", 1'b1, 0, 0, d);
    check("reuse_done_cycle", d, 25);
    run_frame("iv_gap", 1'b0, 1, 0, d);
    check("iv_gap_done_cycle", d, 31);
    run_frame("or_hold", 1'b1, 0, 1, d);
    check("or_hold_done_cycle", d, 30);
    for (int i = 0; i < 4; i++) run_frame("rand", 1'($urandom_range(0, 1)), 2, 2, d);

    // Abort during the kernel load.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("abort_load_in_load", bus.load_sel, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wv_exp = 1'b0;
    check("abort_load_idle", any_out(), 0);

    // Abort during MAC. The loaded weights survive and no done pulse follows.
    run_frame("reload", 1'b0, 0, 0, d);
    bus.start = 1'b1;
    bus.reuse_kernels = 1'b1;
    step();
    bus.start = 1'b0;
    bus.reuse_kernels = 1'b0;
    wait_mac("abort_mac");
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_mac_state", {bus.busy, bus.weights_valid, bus.done}, 3'b010);
    begin
      bit done_seen = 0;
      for (int i = 0; i < 4; i++) begin
        done_seen |= bus.done;
        step();
      end
      check("abort_mac_no_done", done_seen, 0);
    end

    // Reset mid-MAC with start held high.
    bus.start = 1'b1;
    bus.reuse_kernels = 1'b1;
    step();
    bus.start = 1'b0;
    wait_mac("rst_mac");
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    check("rst_mac_outputs", any_out(), 0);
    step();
    check("rst_start_ignored", any_out(), 0);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.reuse_kernels = 1'b0;
    wv_exp = 1'b0;
    step();
    check("rst_release_idle", bus.busy, 0);
    run_frame("post_rst", 1'b1, 0, 0, d);
    check("post_rst_done_cycle", d, 29);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
